// File: rtl/fir_mac_sched.sv
// fir_mac_sched: time-multiplexed FIR controller. Holds the tap delay line and
// coefficient file, feeds one external multiplier one tap per cycle, accumulates
// the products and hands out one filtered result per accepted sample.
module fir_mac_sched #(
  parameter int TAPS = 16,
  parameter int AW   = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_valid,
  output logic               s_ready,
  input  logic signed [31:0] s_data,
  input  logic               coef_we,
  input  logic [AW-1:0]      coef_addr,
  input  logic signed [10:0] coef_data,
  output logic               coef_drop,
  output logic signed [31:0] mul_x,
  output logic signed [10:0] mul_y,
  input  logic signed [31:0] mul_p,
  output logic               m_valid,
  input  logic               m_ready,
  output logic signed [31:0] m_data,
  output logic               busy
);

  localparam int DATA_W = 32;
  localparam int COEF_W = 11;

  typedef enum logic [1:0] {IDLE, MAC, DRAIN, OUT} state_t;

  state_t                    state;
  state_t                    state_nxt;

  logic signed [DATA_W-1:0]  d [TAPS];
  logic signed [COEF_W-1:0]  c [TAPS];
  logic [AW-1:0]             k;
  logic signed [DATA_W-1:0]  prod_q;
  logic                      prod_v;
  logic signed [DATA_W-1:0]  acc;
  logic                      drop_q;

  // Accumulator arithmetic wraps modulo 2^32; overflow is intentionally ignored.
  function automatic logic signed [DATA_W-1:0] add_wrap(
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] b
  );
    return a + b;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // Next-state: accept in IDLE, one MAC cycle per tap, one drain cycle, hold in OUT.
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (s_valid) state_nxt = MAC;
      MAC:     if (k == AW'(TAPS - 1)) state_nxt = DRAIN;
      DRAIN:   state_nxt = OUT;
      OUT:     if (m_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs decoded from the registered state; all handshake flags forced low in reset.
  always_comb begin
    s_ready = !rst && (state == IDLE);
    busy    = !rst && (state != IDLE);
    m_valid = !rst && (state == OUT);
    mul_x   = '0;
    mul_y   = '0;
    if (state == MAC) begin
      mul_x = d[k];
      mul_y = c[k];
    end
  end

  assign coef_drop = drop_q && !rst;

  // Datapath: delay line, coefficient file, tap counter, product/accumulator, result.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < TAPS; i++) begin
        d[i] <= '0;
        c[i] <= '0;
      end
      k      <= '0;
      prod_q <= '0;
      prod_v <= 1'b0;
      acc    <= '0;
      m_data <= '0;
      drop_q <= 1'b0;
    end else begin
      drop_q <= coef_we && (state != IDLE);
      if (coef_we && (state == IDLE)) c[coef_addr] <= coef_data;
      case (state)
        IDLE: begin
          if (s_valid) begin
            d[0] <= s_data;
            for (int i = 1; i < TAPS; i++) d[i] <= d[i-1];
            k      <= '0;
            acc    <= '0;
            prod_v <= 1'b0;
          end
        end
        MAC: begin
          prod_q <= mul_p;
          prod_v <= 1'b1;
          if (prod_v) acc <= add_wrap(acc, prod_q);
          k <= k + AW'(1);
        end
        DRAIN: begin
          m_data <= add_wrap(acc, prod_q);
          prod_v <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_fir_mac_sched.sv
// Bench for fir_mac_sched: directed scenarios followed by randomized samples and
// coefficient writes, checked against a sum-of-products reference model.
module tb_fir_mac_sched;

  localparam int TAPS = 16;
  localparam int AW   = 4;
  localparam int LAT  = TAPS + 2;

  logic               clk;
  logic               rst;
  logic               s_valid;
  logic               s_ready;
  logic signed [31:0] s_data;
  logic               coef_we;
  logic [AW-1:0]      coef_addr;
  logic signed [10:0] coef_data;
  logic               coef_drop;
  logic signed [31:0] mul_x;
  logic signed [10:0] mul_y;
  logic signed [31:0] mul_p;
  logic               m_valid;
  logic               m_ready;
  logic signed [31:0] m_data;
  logic               busy;

  fir_mac_sched #(.TAPS(TAPS), .AW(AW)) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
    .coef_drop(coef_drop),
    .mul_x(mul_x), .mul_y(mul_y), .mul_p(mul_p),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .busy(busy)
  );

  // Multiplier model: low 32 bits of the signed full product.
  logic signed [42:0] mul_full;
  assign mul_full = mul_x * mul_y;
  assign mul_p    = mul_full[31:0];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  int n_cmp = 0;
  int n_err = 0;

  // Reference model state
  logic signed [31:0] mdly  [TAPS];
  logic signed [10:0] mcoef [TAPS];
  logic [31:0]        exp_res;
  int                 t_acc;

  function automatic logic [31:0] model_out();
    logic [31:0]        s = 32'd0;
    logic signed [42:0] p;
    for (int i = 0; i < TAPS; i++) begin
      p = mdly[i] * mcoef[i];
      s = s + p[31:0];
    end
    return s;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < TAPS; i++) begin
      mdly[i]  = '0;
      mcoef[i] = '0;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic wr_coef(input int a, input logic signed [10:0] v);
    coef_we   = 1'b1;
    coef_addr = AW'(a);
    coef_data = v;
    tick();
    coef_we   = 1'b0;
    mcoef[a]  = v;
    chk("idle_write_no_drop", {31'd0, coef_drop}, 32'd0);
  endtask

  // Accept one sample (optionally with a simultaneous coefficient write).
  task automatic start_sample(input logic [31:0] v, input logic we, input int a,
                              input logic signed [10:0] cv, output int waited);
    waited = 0;
    while (!s_ready && waited < 200) begin
      tick();
      waited++;
    end
    if (waited >= 200) chk("s_ready_timeout", 32'd0, 32'd1);
    s_valid   = 1'b1;
    s_data    = v;
    coef_we   = we;
    coef_addr = AW'(a);
    coef_data = cv;
    t_acc     = cyc;
    tick();
    s_valid = 1'b0;
    coef_we = 1'b0;
    if (we) mcoef[a] = cv;
    for (int i = TAPS - 1; i > 0; i--) mdly[i] = mdly[i-1];
    mdly[0] = v;
    exp_res = model_out();
  endtask

  // Wait for the result, optionally stall m_ready for 'hold' cycles, then hand it off.
  task automatic finish_sample(input string tag, input int hold);
    int g;
    logic [31:0] held;
    g = 0;
    m_ready = (hold == 0);
    while (!m_valid && g < 200) begin
      tick();
      g++;
    end
    chk({tag, "_latency"}, 32'(cyc - t_acc), 32'(LAT));
    chk({tag, "_data"}, m_data, exp_res);
    held = m_data;
    for (int i = 0; i < hold; i++) begin
      tick();
      chk({tag, "_bp_ctrl"}, {29'd0, m_valid, s_ready, busy}, 32'b101);
      chk({tag, "_bp_data"}, m_data, held);
    end
    m_ready = 1'b1;
    tick();
    chk({tag, "_post_hs"}, {30'd0, m_valid, s_ready}, 32'b01);
  endtask

  initial begin
    int w;
    int sawv;
    rst       = 1'b1;
    s_valid   = 1'b0;
    s_data    = '0;
    coef_we   = 1'b0;
    coef_addr = '0;
    coef_data = '0;
    m_ready   = 1'b1;
    model_clear();

    // Reset held 3 cycles: every output low
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("rst_ctrl", {28'd0, s_ready, m_valid, coef_drop, busy}, 32'd0);
      chk("rst_mulx", mul_x, 32'd0);
      chk("rst_mdata", m_data, 32'd0);
    end
    rst = 1'b0;
    #1;
    chk("rel_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rel_m_valid", {31'd0, m_valid}, 32'd0);

    // Busy write: rejected during MAC, effective once written in IDLE
    for (int i = 0; i < TAPS; i++) wr_coef(i, 11'sd1);
    start_sample(32'd5, 1'b0, 0, 11'sd0, w);
    coef_we   = 1'b1;
    coef_addr = '0;
    coef_data = 11'sd7;
    tick();
    coef_we = 1'b0;
    chk("drop_pulse", {31'd0, coef_drop}, 32'd1);
    tick();
    chk("drop_single", {31'd0, coef_drop}, 32'd0);
    finish_sample("busywr", 0);
    wr_coef(0, 11'sd7);
    start_sample(32'd0, 1'b0, 0, 11'sd0, w);
    finish_sample("busywr_after", 0);

    // Impulse response with c[k]=k+1
    for (int i = 0; i < TAPS; i++) wr_coef(i, 11'(i + 1));
    start_sample(32'd1, 1'b0, 0, 11'sd0, w);
    finish_sample("impulse", 0);
    for (int i = 1; i < TAPS; i++) begin
      start_sample(32'd0, 1'b0, 0, 11'sd0, w);
      finish_sample("impulse", 0);
    end

    // Back-pressure, then an immediate accept
    start_sample(32'h0000_1234, 1'b0, 0, 11'sd0, w);
    finish_sample("bp", 5);
    start_sample(32'hFFFF_FFF0, 1'b0, 0, 11'sd0, w);
    chk("bp_next_accept_wait", 32'(w), 32'd0);
    finish_sample("bp_next", 0);

    // Wrap-around modulo 2^32
    for (int i = 0; i < TAPS; i++) wr_coef(i, (i < 2) ? 11'sd1 : 11'sd0);
    start_sample(32'h7FFF_FFFF, 1'b0, 0, 11'sd0, w);
    finish_sample("wrap1", 0);
    start_sample(32'h7FFF_FFFF, 1'b0, 0, 11'sd0, w);
    chk("wrap_model", exp_res, 32'hFFFF_FFFE);
    finish_sample("wrap2", 0);

    // Reset in the middle of MAC aborts the sample and clears state
    start_sample(32'd9, 1'b0, 0, 11'sd0, w);
    for (int i = 0; i < 4; i++) tick();
    rst = 1'b1;
    #1;
    chk("midrst_ctrl", {28'd0, s_ready, m_valid, coef_drop, busy}, 32'd0);
    tick();
    chk("midrst_mulx", mul_x, 32'd0);
    rst = 1'b0;
    model_clear();
    sawv = 0;
    for (int i = 0; i < LAT + 4; i++) begin
      tick();
      if (m_valid) sawv++;
    end
    chk("midrst_no_mvalid", 32'(sawv), 32'd0);
    start_sample(32'd0, 1'b0, 0, 11'sd0, w);
    chk("midrst_c_cleared_model", exp_res, 32'd0);
    finish_sample("midrst_c_cleared", 0);
    wr_coef(0, 11'sd1);
    wr_coef(1, 11'sd1);
    start_sample(32'd3, 1'b0, 0, 11'sd0, w);
    finish_sample("midrst_3", 0);

    // Randomized samples, coefficient writes and stalls
    for (int n = 0; n < 30; n++) begin
      int nw;
      nw = $urandom_range(0, 3);
      for (int j = 0; j < nw; j++) wr_coef($urandom_range(0, TAPS - 1), 11'($urandom));
      for (int j = 0; j < int'($urandom_range(0, 2)); j++) tick();
      start_sample($urandom, ($urandom_range(0, 3) == 0), $urandom_range(0, TAPS - 1),
                   11'($urandom), w);
      finish_sample("rand", $urandom_range(0, 3));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
